// File: rtl/wb_commit_unit_if.sv
// Retire-side handshake and data-memory response bundle for wb_commit_unit.
interface wb_commit_unit_if #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned ADDRW     = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [ADDRW-1:0]     in_rd_addr;
  logic [1:0]           in_wb_sel;
  logic [2:0]           in_funct3;
  logic [DATAWIDTH-1:0] in_alu_result;
  logic [DATAWIDTH-1:0] in_pc_plus4;
  logic                 mem_rvalid;
  logic [DATAWIDTH-1:0] mem_rdata;

  // Pipeline / memory side: presents instructions and load data.
  modport master (
    output in_valid, in_rd_addr, in_wb_sel, in_funct3, in_alu_result, in_pc_plus4,
    output mem_rvalid, mem_rdata,
    input  in_ready
  );

  // Commit unit side.
  modport slave (
    input  in_valid, in_rd_addr, in_wb_sel, in_funct3, in_alu_result, in_pc_plus4,
    input  mem_rvalid, mem_rdata,
    output in_ready
  );
endinterface

// File: rtl/wb_commit_unit.sv
// Write-back commit stage: selects ALU / PC+4 / load result, drives a
// registered single-cycle register-file write and a last-write bypass.
module wb_commit_unit #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned ADDRW     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_commit_unit_if.slave      bus,
  output logic                 wren,
  output logic [ADDRW-1:0]     rd_addr,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 fwd_valid,
  output logic [ADDRW-1:0]     fwd_addr,
  output logic [DATAWIDTH-1:0] fwd_data,
  output logic                 err,
  output logic                 busy
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [ADDRW-1:0]     ld_rd_q;
  logic [2:0]           ld_funct3_q;
  logic [1:0]           ld_off_q;

  logic                 capture;
  logic                 commit_req;
  logic                 drop;
  logic [ADDRW-1:0]     commit_addr;
  logic [DATAWIDTH-1:0] commit_data;

  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [DATAWIDTH-1:0] load_data;
  logic                 load_ok;

  // Handshake and status decode from the state register only.
  assign bus.in_ready = (state_q == IDLE);
  assign busy         = (state_q == WAIT_MEM);

  // Align and extend the returned memory word; flag illegal type/offset.
  always_comb begin
    ld_byte   = '0;
    ld_half   = '0;
    load_data = '0;
    load_ok   = 1'b0;
    unique case (ld_off_q)
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = ld_off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (ld_funct3_q)
      3'b000: begin
        load_data = {{(DATAWIDTH-8){ld_byte[7]}}, ld_byte};
        load_ok   = 1'b1;
      end
      3'b100: begin
        load_data = {{(DATAWIDTH-8){1'b0}}, ld_byte};
        load_ok   = 1'b1;
      end
      3'b001: begin
        load_data = {{(DATAWIDTH-16){ld_half[15]}}, ld_half};
        load_ok   = ~ld_off_q[0];
      end
      3'b101: begin
        load_data = {{(DATAWIDTH-16){1'b0}}, ld_half};
        load_ok   = ~ld_off_q[0];
      end
      3'b010: begin
        load_data = bus.mem_rdata;
        load_ok   = (ld_off_q == 2'd0);
      end
      default: begin
        load_data = '0;
        load_ok   = 1'b0;
      end
    endcase
  end

  // Next state and the commit request that the output registers latch.
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    commit_req  = 1'b0;
    drop        = 1'b0;
    commit_addr = bus.in_rd_addr;
    commit_data = bus.in_alu_result;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          case (bus.in_wb_sel)
            2'b00: commit_req = 1'b1;
            2'b10: begin
              commit_req  = 1'b1;
              commit_data = bus.in_pc_plus4;
            end
            2'b01: begin
              capture = 1'b1;
              state_d = WAIT_MEM;
            end
            default: ;
          endcase
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          state_d     = IDLE;
          commit_addr = ld_rd_q;
          commit_data = load_data;
          commit_req  = load_ok;
          drop        = ~load_ok;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any outstanding load.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Capture load destination and alignment info at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_rd_q     <= '0;
      ld_funct3_q <= '0;
      ld_off_q    <= '0;
    end else if (capture) begin
      ld_rd_q     <= bus.in_rd_addr;
      ld_funct3_q <= bus.in_funct3;
      ld_off_q    <= bus.in_alu_result[1:0];
    end
  end

  // Registered write strobe, error pulse and bypass entry; x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      wren      <= 1'b0;
      rd_addr   <= '0;
      rd_data   <= '0;
      err       <= 1'b0;
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      fwd_data  <= '0;
    end else begin
      wren <= commit_req && (commit_addr != '0);
      err  <= drop;
      if (commit_req && (commit_addr != '0)) begin
        rd_addr   <= commit_addr;
        rd_data   <= commit_data;
        fwd_valid <= 1'b1;
        fwd_addr  <= commit_addr;
        fwd_data  <= commit_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit: directed scenarios plus random
// traffic, all compared every cycle against a behavioural model.
module tb_wb_commit_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wren, fwd_valid, err, busy;
  logic [4:0]  rd_addr, fwd_addr;
  logic [31:0] rd_data, fwd_data;

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          started = 1'b0;
  logic [4:0]  commit_log[$];

  wb_commit_unit_if #(.DATAWIDTH(32), .ADDRW(5)) bus ();

  wb_commit_unit #(.DATAWIDTH(32), .ADDRW(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .wren     (wren),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .fwd_valid(fwd_valid),
    .fwd_addr (fwd_addr),
    .fwd_data (fwd_data),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_pend;
  logic [4:0]  m_ld_rd;
  logic [2:0]  m_ld_f3;
  logic [1:0]  m_ld_off;
  logic        m_wren, m_err, m_fv;
  logic [4:0]  m_rd_addr, m_fa;
  logic [31:0] m_rd_data, m_fd;

  // Returns {ok, value} for a load of type f3 at byte offset off within word.
  function automatic logic [32:0] load_model(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] word);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = word >> (8 * int'(off));
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000: return {1'b1, 32'($signed(b))};
      3'b100: return {1'b1, 32'(b)};
      3'b001: return {off[0] == 1'b0, 32'($signed(h))};
      3'b101: return {off[0] == 1'b0, 32'(h)};
      3'b010: return {off == 2'd0, word};
      default: return {1'b0, 32'h0};
    endcase
  endfunction

  function automatic void m_write(input logic [4:0] a, input logic [31:0] d);
    if (a != 5'd0) begin
      m_wren = 1'b1; m_rd_addr = a; m_rd_data = d;
      m_fv = 1'b1; m_fa = a; m_fd = d;
    end
  endfunction

  always @(posedge clk) begin : model
    logic [32:0] r;
    if (rst) begin
      started = 1'b1;
      m_pend = 1'b0; m_ld_rd = '0; m_ld_f3 = '0; m_ld_off = '0;
      m_wren = 1'b0; m_err = 1'b0; m_fv = 1'b0;
      m_rd_addr = '0; m_fa = '0; m_rd_data = '0; m_fd = '0;
    end else begin
      m_wren = 1'b0;
      m_err  = 1'b0;
      if (!m_pend) begin
        if (bus.in_valid) begin
          if (bus.in_wb_sel == 2'b00) m_write(bus.in_rd_addr, bus.in_alu_result);
          else if (bus.in_wb_sel == 2'b10) m_write(bus.in_rd_addr, bus.in_pc_plus4);
          else if (bus.in_wb_sel == 2'b01) begin
            m_pend   = 1'b1;
            m_ld_rd  = bus.in_rd_addr;
            m_ld_f3  = bus.in_funct3;
            m_ld_off = bus.in_alu_result[1:0];
          end
        end
      end else if (bus.mem_rvalid) begin
        m_pend = 1'b0;
        r = load_model(m_ld_f3, m_ld_off, bus.mem_rdata);
        if (r[32]) m_write(m_ld_rd, r[31:0]);
        else m_err = 1'b1;
      end
    end
  end

  // Compare DUT against the model on every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (started) begin
      chk("wren",      32'(wren),         32'(m_wren));
      chk("err",       32'(err),          32'(m_err));
      chk("in_ready",  32'(bus.in_ready), 32'(!m_pend));
      chk("busy",      32'(busy),         32'(m_pend));
      chk("rd_addr",   32'(rd_addr),      32'(m_rd_addr));
      chk("rd_data",   rd_data,           m_rd_data);
      chk("fwd_valid", 32'(fwd_valid),    32'(m_fv));
      chk("fwd_addr",  32'(fwd_addr),     32'(m_fa));
      chk("fwd_data",  fwd_data,          m_fd);
      if (wren === 1'b1) commit_log.push_back(rd_addr);
    end
  end

  // ---------------- stimulus helpers (all start and end on a falling edge) ----------------
  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.in_rd_addr = '0; bus.in_wb_sel = '0; bus.in_funct3 = '0;
    bus.in_alu_result = '0; bus.in_pc_plus4 = '0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one instruction and hold it until accepted; returns in the cycle after accept.
  task automatic issue(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_rd_addr = rd; bus.in_wb_sel = sel;
    bus.in_funct3 = f3; bus.in_alu_result = alu; bus.in_pc_plus4 = pc;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Issue a load, respond after dly wait cycles, then check the commit or drop.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] word, input int dly, input bit bad,
                         input logic [31:0] exp);
    issue(rd, 2'b01, f3, addr, 32'h0);
    for (int i = 0; i < dly; i++) begin
      chk("ready_in_wait", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    chk("ready_in_wait", 32'(bus.in_ready), 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = word;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    if (bad) begin
      chk("drop_err", 32'(err), 32'd1);
      chk("drop_wren", 32'(wren), 32'd0);
    end else begin
      chk("load_wren", 32'(wren), 32'd1);
      chk("load_data", rd_data, exp);
    end
    chk("ready_after_load", 32'(bus.in_ready), 32'd1);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    @(negedge clk);
    do_reset();
    chk("reset_wren", 32'(wren), 32'd0);
    chk("reset_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("reset_ready", 32'(bus.in_ready), 32'd1);

    // ALU write x5
    issue(5'd5, 2'b00, 3'b000, 32'hDEADBEEF, 32'h0);
    chk("alu_wren", 32'(wren), 32'd1);
    chk("alu_rd_addr", 32'(rd_addr), 32'd5);
    chk("alu_rd_data", rd_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("alu_wren_once", 32'(wren), 32'd0);
    chk("alu_fwd_addr", 32'(fwd_addr), 32'd5);
    chk("alu_fwd_data", fwd_data, 32'hDEADBEEF);

    // Load alignment sweep
    do_load(5'd6,  3'b000, 32'h1000, 32'h80F17F82, 0, 1'b0, 32'hFFFFFF82);
    do_load(5'd7,  3'b100, 32'h1003, 32'h80F17F82, 2, 1'b0, 32'h00000080);
    do_load(5'd8,  3'b001, 32'h1002, 32'h80F17F82, 1, 1'b0, 32'hFFFF80F1);
    do_load(5'd9,  3'b101, 32'h1000, 32'h80F17F82, 0, 1'b0, 32'h00007F82);
    do_load(5'd10, 3'b010, 32'h1000, 32'h80F17F82, 3, 1'b0, 32'h80F17F82);

    // Misaligned / illegal loads are dropped with an err pulse
    do_load(5'd11, 3'b010, 32'h1002, 32'h12345678, 0, 1'b1, 32'h0);
    do_load(5'd12, 3'b001, 32'h1001, 32'h12345678, 1, 1'b1, 32'h0);
    do_load(5'd13, 3'b011, 32'h1000, 32'h12345678, 0, 1'b1, 32'h0);
    @(negedge clk);
    chk("err_one_cycle", 32'(err), 32'd0);
    chk("drop_fwd_addr", 32'(fwd_addr), 32'd10);
    chk("drop_fwd_data", fwd_data, 32'h80F17F82);

    // x0 and no-write instructions
    issue(5'd0, 2'b00, 3'b000, 32'h00001234, 32'h0);
    chk("x0_wren", 32'(wren), 32'd0);
    issue(5'd9, 2'b11, 3'b000, 32'h0, 32'h00000444);
    chk("nowb_wren", 32'(wren), 32'd0);
    chk("nowb_fwd_addr", 32'(fwd_addr), 32'd10);
    chk("nowb_fwd_valid", 32'(fwd_valid), 32'd1);

    // Back-to-back: ALU x1, load x2 (3-cycle memory), PC+4 x3 held while busy
    commit_log.delete();
    issue(5'd1, 2'b00, 3'b000, 32'h00000111, 32'h0);
    issue(5'd2, 2'b01, 3'b010, 32'h00002000, 32'h0);
    bus.in_valid = 1'b1; bus.in_rd_addr = 5'd3; bus.in_wb_sel = 2'b10;
    bus.in_alu_result = 32'h0; bus.in_pc_plus4 = 32'h00000333;
    @(negedge clk);
    chk("b2b_blocked", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("b2b_blocked", 32'(bus.in_ready), 32'd0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00000222;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    chk("b2b_load_addr", 32'(rd_addr), 32'd2);
    chk("b2b_load_data", rd_data, 32'h00000222);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b_pc_addr", 32'(rd_addr), 32'd3);
    chk("b2b_pc_data", rd_data, 32'h00000333);
    @(negedge clk);
    chk("b2b_count", 32'(commit_log.size()), 32'd3);
    if (commit_log.size() == 3) begin
      chk("b2b_order0", 32'(commit_log[0]), 32'd1);
      chk("b2b_order1", 32'(commit_log[1]), 32'd2);
      chk("b2b_order2", 32'(commit_log[2]), 32'd3);
    end

    // Reset mid-load
    issue(5'd7, 2'b01, 3'b010, 32'h00003000, 32'h0);
    chk("midload_busy", 32'(busy), 32'd1);
    do_reset();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    chk("midload_wren", 32'(wren), 32'd0);
    chk("midload_err", 32'(err), 32'd0);
    chk("midload_ready", 32'(bus.in_ready), 32'd1);
    chk("midload_fwd_valid", 32'(fwd_valid), 32'd0);

    // Random traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      rst               = ($urandom_range(0, 199) == 0);
      bus.in_valid      = ($urandom_range(0, 9) < 7);
      bus.in_rd_addr    = 5'($urandom_range(0, 31));
      bus.in_wb_sel     = 2'($urandom_range(0, 3));
      bus.in_funct3     = 3'($urandom_range(0, 7));
      bus.in_alu_result = $urandom();
      bus.in_pc_plus4   = $urandom();
      bus.mem_rvalid    = ($urandom_range(0, 9) < 4);
      bus.mem_rdata     = $urandom();
      @(negedge clk);
    end
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
